// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Purpose:
//    Main control FSM for the multi-cycle RISC-V datapath. It decodes the opcode
//    of the latched instruction and steps through fetch, decode, execute, memory
//    and writeback, one state per clock. In every state it drives the datapath
//    mux selects, the write strobes and the ALU_OP code for ALU_CONTROL.
//
// Configuration macro:
//    ILLEGAL_TRAP_EN : when defined, an unsupported opcode in DECODE sends the
//                      FSM to ERROR (state 15) and sets the sticky o_illegal_op
//                      flag until reset. When undefined, an unsupported opcode
//                      runs as a two-cycle nop and o_illegal_op is tied to 0.
//
// Ports:
//    i_clk          rising-edge clock
//    i_rst          asynchronous active-high reset
//    i_instruccion  instruction register output (opcode in bits [6:0])
//    i_zero         ALU zero flag
//    o_PCWrite      PC write strobe = PCUpdate | (Branch & zero)
//    o_AdrSrc       memory address select (0=PC, 1=Result)
//    o_MemWrite     data memory write strobe
//    o_IRWrite      instruction register write strobe
//    o_RegWrite     register file write strobe
//    o_ResultSrc    00=ALUOut, 01=Data, 10=ALUResult
//    o_ALUSrcA      00=PC, 01=OldPC, 10=RegA
//    o_ALUSrcB      00=RegB, 01=ImmExt, 10=const 4
//    o_ALU_OP       00 add, 01 sub, 10 funct-decoded
//    o_estado       current state code
//    o_illegal_op   sticky illegal-opcode flag
// -----------------------------------------------------------------------------
module multicycle_control #(
   parameter int width_instruction = 32
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [width_instruction-1:0] i_instruccion,
   input  logic                         i_zero,
   output logic                         o_PCWrite,
   output logic                         o_AdrSrc,
   output logic                         o_MemWrite,
   output logic                         o_IRWrite,
   output logic                         o_RegWrite,
   output logic [1:0]                   o_ResultSrc,
   output logic [1:0]                   o_ALUSrcA,
   output logic [1:0]                   o_ALUSrcB,
   output logic [1:0]                   o_ALU_OP,
   output logic [3:0]                   o_estado,
   output logic                         o_illegal_op
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_ERROR    = 4'd15
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [6:0]  w_opcode;
   logic        w_unused_bits;

   // Raw Moore decode, before the reset gate
   logic        w_pc_update;
   logic        w_branch;
   logic        w_adr_src;
   logic        w_mem_write;
   logic        w_ir_write;
   logic        w_reg_write;
   logic [1:0]  w_result_src;
   logic [1:0]  w_alu_src_a;
   logic [1:0]  w_alu_src_b;
   logic [1:0]  w_alu_op;

   assign w_opcode      = i_instruccion[6:0];
   // Only the opcode field matters here; the rest is folded away on purpose.
   assign w_unused_bits = ^i_instruccion[width_instruction-1:7];

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; the opcode is re-read in every state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_FETCH: w_next_state = S_DECODE;
         S_DECODE: begin
            case (w_opcode)
               OP_LW, OP_SW: w_next_state = S_MEMADR;
               OP_R:         w_next_state = S_EXECUTER;
               OP_I:         w_next_state = S_EXECUTEI;
               OP_JAL:       w_next_state = S_JAL;
               OP_BEQ:       w_next_state = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
               default:      w_next_state = S_ERROR;
`else
               default:      w_next_state = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            if (w_opcode == OP_SW) begin
               w_next_state = S_MEMWRITE;
            end else begin
               w_next_state = S_MEMREAD;
            end
         end
         S_MEMREAD:  w_next_state = S_MEMWB;
         S_MEMWB:    w_next_state = S_FETCH;
         S_MEMWRITE: w_next_state = S_FETCH;
         S_EXECUTER: w_next_state = S_ALUWB;
         S_EXECUTEI: w_next_state = S_ALUWB;
         S_JAL:      w_next_state = S_ALUWB;
         S_ALUWB:    w_next_state = S_FETCH;
         S_BEQ:      w_next_state = S_FETCH;
         S_ERROR:    w_next_state = S_ERROR;
         default:    w_next_state = S_FETCH;
      endcase
   end

   // Moore output decode from the current state
   always_comb begin
      w_pc_update  = 1'b0;
      w_branch     = 1'b0;
      w_adr_src    = 1'b0;
      w_mem_write  = 1'b0;
      w_ir_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_result_src = 2'b00;
      w_alu_src_a  = 2'b00;
      w_alu_src_b  = 2'b00;
      w_alu_op     = 2'b00;
      case (r_state)
         S_FETCH: begin
            w_ir_write   = 1'b1;
            w_pc_update  = 1'b1;
            w_alu_src_b  = 2'b10;
            w_result_src = 2'b10;
         end
         S_DECODE: begin
            // Precompute the branch target from OldPC + imm
            w_alu_src_a = 2'b01;
            w_alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            w_alu_src_a = 2'b10;
            w_alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            w_adr_src = 1'b1;
         end
         S_MEMWB: begin
            w_result_src = 2'b01;
            w_reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            w_adr_src   = 1'b1;
            w_mem_write = 1'b1;
         end
         S_EXECUTER: begin
            w_alu_src_a = 2'b10;
            w_alu_op    = 2'b10;
         end
         S_EXECUTEI: begin
            w_alu_src_a = 2'b10;
            w_alu_src_b = 2'b01;
            w_alu_op    = 2'b10;
         end
         S_JAL: begin
            w_alu_src_a = 2'b01;
            w_alu_src_b = 2'b10;
            w_pc_update = 1'b1;
         end
         S_ALUWB: begin
            w_reg_write = 1'b1;
         end
         S_BEQ: begin
            w_alu_src_a = 2'b10;
            w_alu_op    = 2'b01;
            w_branch    = 1'b1;
         end
         S_ERROR: begin
            w_pc_update = 1'b0;
         end
         default: begin
            w_pc_update = 1'b0;
         end
      endcase
   end

   // Reset gate: the state register already sits in FETCH during reset, but
   // FETCH's strobes must not leak out while i_rst is high.
   always_comb begin
      if (i_rst) begin
         o_PCWrite   = 1'b0;
         o_AdrSrc    = 1'b0;
         o_MemWrite  = 1'b0;
         o_IRWrite   = 1'b0;
         o_RegWrite  = 1'b0;
         o_ResultSrc = 2'b00;
         o_ALUSrcA   = 2'b00;
         o_ALUSrcB   = 2'b00;
         o_ALU_OP    = 2'b00;
      end else begin
         // Branch decision follows zero combinationally within the BEQ cycle
         o_PCWrite   = w_pc_update | (w_branch & i_zero);
         o_AdrSrc    = w_adr_src;
         o_MemWrite  = w_mem_write;
         o_IRWrite   = w_ir_write;
         o_RegWrite  = w_reg_write;
         o_ResultSrc = w_result_src;
         o_ALUSrcA   = w_alu_src_a;
         o_ALUSrcB   = w_alu_src_b;
         o_ALU_OP    = w_alu_op;
      end
   end

   assign o_estado = r_state;

`ifdef ILLEGAL_TRAP_EN
   logic r_illegal;

   // Sticky illegal-opcode flag, set on the edge that enters ERROR
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_illegal <= 1'b0;
      end else if (w_next_state == S_ERROR) begin
         r_illegal <= 1'b1;
      end else begin
         r_illegal <= r_illegal;
      end
   end

   assign o_illegal_op = r_illegal;
`else
   assign o_illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Self-checking bench for multicycle_control: a table of per-opcode state
// sequences, hand-written corner sequences (reset mid-instruction, illegal
// opcode) and randomized instruction streams checked against a reference model
// that derives the per-instruction state list and per-state outputs directly
// from the control table.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        zero;
   logic        pcw, adr, memw, irw, regw;
   logic [1:0]  res, srca, srcb, aluop;
   logic [3:0]  estado;
   logic        illegal;
   logic [12:0] vec;

   int total = 0;
   int bad   = 0;
   int m_seq[$];

   always #5 clk = ~clk;

   assign vec = {pcw, adr, memw, irw, regw, res, srca, srcb, aluop};

   multicycle_control #(.width_instruction(32)) dut (
      .i_clk(clk), .i_rst(rst), .i_instruccion(instr), .i_zero(zero),
      .o_PCWrite(pcw), .o_AdrSrc(adr), .o_MemWrite(memw), .o_IRWrite(irw),
      .o_RegWrite(regw), .o_ResultSrc(res), .o_ALUSrcA(srca), .o_ALUSrcB(srcb),
      .o_ALU_OP(aluop), .o_estado(estado), .o_illegal_op(illegal)
   );

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, BEQ = 7'b1100011, JAL = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected outputs for a state, straight from the control table
   function automatic logic [12:0] model_out(int st, logic z);
      logic pcu = 1'b0, br = 1'b0, a = 1'b0, mw = 1'b0, iw = 1'b0, rw = 1'b0;
      logic [1:0] rs = 2'd0, sa = 2'd0, sb = 2'd0, op = 2'd0;
      case (st)
         0:  begin iw = 1'b1; pcu = 1'b1; sb = 2'd2; rs = 2'd2; end
         1:  begin sa = 2'd1; sb = 2'd1; end
         2:  begin sa = 2'd2; sb = 2'd1; end
         3:  a = 1'b1;
         4:  begin rs = 2'd1; rw = 1'b1; end
         5:  begin a = 1'b1; mw = 1'b1; end
         6:  begin sa = 2'd2; op = 2'd2; end
         7:  rw = 1'b1;
         8:  begin sa = 2'd2; sb = 2'd1; op = 2'd2; end
         9:  begin sa = 2'd1; sb = 2'd2; pcu = 1'b1; end
         10: begin sa = 2'd2; op = 2'd1; br = 1'b1; end
         default: ;
      endcase
      return {pcu | (br & z), a, mw, iw, rw, rs, sa, sb, op};
   endfunction

   // States visited by one instruction, FETCH first (non-trapping illegal = nop)
   function automatic void build_seq(logic [6:0] op);
      m_seq.delete();
      m_seq.push_back(0);
      m_seq.push_back(1);
      case (op)
         LW:  begin m_seq.push_back(2); m_seq.push_back(3); m_seq.push_back(4); end
         SW:  begin m_seq.push_back(2); m_seq.push_back(5); end
         RT:  begin m_seq.push_back(6); m_seq.push_back(7); end
         IT:  begin m_seq.push_back(8); m_seq.push_back(7); end
         JAL: begin m_seq.push_back(9); m_seq.push_back(7); end
         BEQ: m_seq.push_back(10);
         default: ;
      endcase
   endfunction

   task automatic check_cycle(input string tag, input int st);
      check({tag, " estado"}, 32'(estado), 32'(st));
      check({tag, " outs"}, 32'(vec), 32'(model_out(st, zero)));
      check({tag, " illegal"}, 32'(illegal), 32'(st == 15));
   endtask

   // Runs one instruction starting in FETCH (called just after a posedge)
   task automatic run_instr(input logic [6:0] op, input bit rnd_zero, input logic z,
                            input string tag);
      build_seq(op);
      for (int k = 0; k < m_seq.size(); k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end else begin
            instr = {25'($urandom), op};
         end
         zero = rnd_zero ? 1'($urandom) : z;
         @(negedge clk);
         check_cycle(tag, m_seq[k]);
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [6:0]  op;
      logic        z;
      int          len;
      logic [19:0] sts;
   } vec_t;

   vec_t tbl[8];
   int   tbl_n;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{LW,  1'b0, 5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4}};
      tbl[1] = '{SW,  1'b1, 4, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0}};
      tbl[2] = '{RT,  1'b0, 4, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0}};
      tbl[3] = '{IT,  1'b1, 4, {4'd0, 4'd1, 4'd8, 4'd7, 4'd0}};
      tbl[4] = '{JAL, 1'b0, 4, {4'd0, 4'd1, 4'd9, 4'd7, 4'd0}};
      tbl[5] = '{BEQ, 1'b1, 3, {4'd0, 4'd1, 4'd10, 4'd0, 4'd0}};
      tbl[6] = '{BEQ, 1'b0, 3, {4'd0, 4'd1, 4'd10, 4'd0, 4'd0}};
      tbl[7] = '{BAD, 1'b1, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0}};
`ifdef ILLEGAL_TRAP_EN
      tbl_n = 7;
`else
      tbl_n = 8;
`endif

      // Reset state: FETCH code, everything quiet
      rst = 1'b1; instr = {25'd0, LW}; zero = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset estado", 32'(estado), 32'd0);
      check("reset outs", 32'(vec), 32'd0);
      check("reset illegal", 32'(illegal), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Table-driven per-opcode sequences
      for (int i = 0; i < tbl_n; i++) begin
         instr = {25'($urandom), tbl[i].op};
         zero  = tbl[i].z;
         for (int k = 0; k < tbl[i].len; k++) begin
            logic [19:0] s;
            if (k > 0) begin
               @(posedge clk); #1;
            end
            @(negedge clk);
            s = tbl[i].sts << (4 * k);
            check($sformatf("tbl%0d st%0d estado", i, k), 32'(estado), 32'(s[19:16]));
            check($sformatf("tbl%0d st%0d outs", i, k), 32'(vec),
                  32'(model_out(int'(s[19:16]), zero)));
            check($sformatf("tbl%0d st%0d illegal", i, k), 32'(illegal), 32'd0);
         end
         @(posedge clk); #1;
      end

      // Reset asserted in MEMREAD aborts the load before its writeback
      instr = {25'd0, LW}; zero = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         @(negedge clk);
      end
      check("pre-abort estado", 32'(estado), 32'd3);
      #2 rst = 1'b1;
      #1;
      check("abort estado", 32'(estado), 32'd0);
      check("abort outs", 32'(vec), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check("abort regwrite", 32'(regw), 32'd0);
         check("abort hold estado", 32'(estado), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      run_instr(LW, 1'b0, 1'b0, "post-abort lw");

`ifdef ILLEGAL_TRAP_EN
      // Illegal opcode traps into ERROR until reset
      instr = {25'd0, BAD};
      @(negedge clk); check_cycle("trap fetch", 0);
      @(posedge clk); #1; @(negedge clk); check_cycle("trap decode", 1);
      repeat (4) begin
         @(posedge clk); #1; @(negedge clk);
         check_cycle("trap hold", 15);
      end
      rst = 1'b1; #1;
      check("trap rst estado", 32'(estado), 32'd0);
      check("trap rst illegal", 32'(illegal), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
`endif

      // Randomized instruction stream
      for (int n = 0; n < 80; n++) begin
         logic [6:0] op;
         case ($urandom_range(0, 7))
            0: op = LW;
            1: op = SW;
            2: op = RT;
            3: op = IT;
            4: op = BEQ;
            5: op = JAL;
            default: op = 7'($urandom);
         endcase
`ifdef ILLEGAL_TRAP_EN
         if (!(op inside {LW, SW, RT, IT, BEQ, JAL})) op = LW;
`endif
         run_instr(op, 1'b1, 1'b0, $sformatf("rnd%0d op%07b", n, op));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control FSM for the RISC-V datapath, directly upstream of `ALU_CONTROL`. It decodes the opcode of the latched instruction and sequences fetch, decode, execute, memory and writeback one state per clock. Each cycle it drives the datapath mux selects and write strobes, and drives `ALU_OP` (00 add, 01 sub, 10 funct-decoded) to `ALU_CONTROL`.

## Interface
- `width_instruction`, default 32: instruction width; the opcode is bits [6:0].
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `instruccion`  in  width_instruction  instruction register output; stable from the cycle after FETCH
- `zero`  in  1  ALU zero flag
- `PCWrite`  out  1  computed as `PCUpdate | (Branch & zero)`
- `AdrSrc`  out  1  0=PC, 1=Result
- `MemWrite`, `IRWrite`, `RegWrite`  out  1 each  write strobes
- `ResultSrc`  out  2  00=ALUOut, 01=Data, 10=ALUResult
- `ALUSrcA`  out  2  00=PC, 01=OldPC, 10=RegA
- `ALUSrcB`  out  2  00=RegB, 01=ImmExt, 10=const 4
- `ALU_OP`  out  2  to `ALU_CONTROL`
- `estado`  out  4  current state code
- `illegal_op`  out  1  sticky illegal-opcode flag

## Operation
- Supported opcodes: lw=0000011, sw=0100011, R=0110011, I-ALU=0010011, beq=1100011, jal=1101111.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, ERROR=15.
- Outputs are Moore, decoded from state only; `PCWrite` also depends on `zero`. Selects not listed below are 00; strobes not listed are 0.
  - FETCH: IRWrite=1, PCUpdate=1, ALUSrcB=10, ResultSrc=10, ALU_OP=00.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALU_OP=00 (branch target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALU_OP=00.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALU_OP=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALU_OP=10.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
  - ALUWB: RegWrite=1.
  - BEQ: ALUSrcA=10, ALU_OP=01, Branch=1.
  - ERROR: everything 0.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (lw/sw), EXECUTER (R), EXECUTEI (I), JAL, BEQ; any other opcode goes per Configuration.
  - MEMADR→MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD→MEMWB→FETCH; MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI/JAL→ALUWB→FETCH; BEQ→FETCH.
  - ERROR→ERROR until reset.
- Opcode is re-read every state; the datapath guarantees `instruccion` holds constant from DECODE until the next FETCH.

## Timing
- Reset: `estado`=0 (FETCH). While `rst`=1, all strobes (`PCWrite`, `MemWrite`, `IRWrite`, `RegWrite`) are forced 0, selects are 00 and `illegal_op`=0. The first FETCH strobes assert in the first cycle after `rst` falls.
- Reset asserted mid-instruction aborts it immediately and asynchronously; no partial write strobe is issued after `rst` rises.
- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- BEQ: `PCWrite` follows `zero` combinationally within the BEQ cycle.

## Configuration
- `ILLEGAL_TRAP_EN` defined: an unsupported opcode in DECODE goes to ERROR; `illegal_op` rises the next cycle and stays 1 until reset.
- `ILLEGAL_TRAP_EN` undefined: an unsupported opcode in DECODE returns to FETCH (executes as a 2-cycle nop); `illegal_op` is tied 0 and state 15 is unreachable.

## Test plan
- Reset then release with lw opcode: `estado` sequence 0,1,2,3,4,0; `RegWrite`=1 only in state 4; `IRWrite`=1 only in state 0.
- sw: sequence 0,1,2,5,0; `MemWrite`=1 and `AdrSrc`=1 only in state 5.
- R-type: `ALU_OP`=10 in state 6; I-type: `ALU_OP`=10 with `ALUSrcB`=01 in state 8; both followed by ALUWB with `RegWrite`=1.
- beq: in state 10 with `zero`=1 → `PCWrite`=1, `ALU_OP`=01; repeat with `zero`=0 → `PCWrite`=0; next state is 0.
- jal: sequence 0,1,9,7,0; `PCWrite`=1 in states 0 and 9.
- Opcode 1111111 with `ILLEGAL_TRAP_EN`: `estado`=15 and `illegal_op`=1 held until `rst`. Without the macro: back to 0 after DECODE, `illegal_op`=0. Also assert `rst` during MEMREAD → `estado`=0 immediately, `RegWrite` never asserted.
